// File: rtl/approx_acc_pkg.sv
// rtl/approx_acc_pkg.sv - shared FSM encoding and default widths for the approximate MAC accumulator
package approx_acc_pkg;

    localparam int PROD_W_DEF = 16;
    localparam int ACC_W_DEF  = 24;
    localparam int CNT_W_DEF  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } acc_state_t;

endpackage

// File: rtl/approx_acc_adder.sv
// rtl/approx_acc_adder.sv - combinational accumulator adder with carry; APPROX_ACC_SATURATE_EN clamps on carry
module approx_acc_adder #(
    parameter int ACC_W = 24
) (
    input  logic [ACC_W-1:0] a,
    input  logic [ACC_W-1:0] b,
    output logic [ACC_W-1:0] sum,
    output logic             carry
);

    logic [ACC_W:0] full;

    assign full  = {1'b0, a} + {1'b0, b};
    assign carry = full[ACC_W];

`ifdef APPROX_ACC_SATURATE_EN
    // Once pinned at all-ones, any further nonzero addend carries again, so the value stays clamped
    assign sum = carry ? {ACC_W{1'b1}} : full[ACC_W-1:0];
`else
    assign sum = full[ACC_W-1:0];
`endif

endmodule

// File: rtl/approx_mac_accumulator.sv
// rtl/approx_mac_accumulator.sv - sums a programmed number of products, gates the multiplier; APPROX_ACC_SATURATE_EN selects saturation
module approx_mac_accumulator
    import approx_acc_pkg::*;
#(
    parameter int PROD_W = PROD_W_DEF,
    parameter int ACC_W  = ACC_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  len,
    output logic              mult_en,
    input  logic              prod_valid,
    input  logic [PROD_W-1:0] prod,
    output logic              prod_ready,
    output logic [ACC_W-1:0]  acc_out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              ovf
);

    acc_state_t       state;
    acc_state_t       next_state;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] len_q;
    logic [ACC_W-1:0] sum;
    logic             carry;
    logic             beat;
    logic             last_beat;

    approx_acc_adder #(.ACC_W(ACC_W)) u_adder (
        .a     (acc),
        .b     (ACC_W'(prod)),
        .sum   (sum),
        .carry (carry)
    );

    assign beat       = prod_valid && (state == ACCUM);
    assign last_beat  = beat && (cnt == len_q - CNT_W'(1));
    assign prod_ready = (state == ACCUM);
    assign mult_en    = (state == ACCUM);
    assign out_valid  = (state == DONE);
    assign busy       = (state != IDLE);

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = (len != '0) ? ACCUM : DONE;
            ACCUM:   if (last_beat) next_state = DONE;
            DONE:    if (out_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            acc     <= '0;
            cnt     <= '0;
            len_q   <= '0;
            acc_out <= '0;
            ovf     <= 1'b0;
        end else begin
            state <= next_state;
            case (state)
                IDLE: begin
                    if (start) begin
                        acc   <= '0;
                        cnt   <= '0;
                        ovf   <= 1'b0;
                        len_q <= len;
                        // An empty run publishes zero straight away
                        if (len == '0) acc_out <= '0;
                    end
                end
                ACCUM: begin
                    if (beat) begin
                        acc <= sum;
                        cnt <= cnt + CNT_W'(1);
                        if (carry) ovf <= 1'b1;
                        if (last_beat) acc_out <= sum;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
